seg_scroll_display: RTL and testbench

//  Parametrised multi-digit 7-segment driver; successor to the fixed 8-digit pattern block.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_tick_gen.sv | 39 +++
 rtl/seg_scroll_display.sv | 141 ++++++++++++++
 tb/tb_seg_scroll_display.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - mode codes, blank pattern and hex-to-7-segment decode for the scroll display
package seg_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_STATIC = 2'b01;
    localparam logic [1:0] MODE_SCROLL = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit6..0 = a..g
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// rtl/seg_tick_gen.sv - free-running prescaler producing one tick every TICK_DIV cycles
module seg_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Hold freezes the count in place so a paused scroll resumes mid-period
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !hold && (cnt_q == CNT_LAST);

endmodule

// File: rtl/seg_scroll_display.sv
// rtl/seg_scroll_display.sv - multi-digit 7-segment driver with static, scroll and blink modes
module seg_scroll_display
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int MSG_LEN  = 16,
    parameter int TICK_DIV = 25_000_000,
    localparam int AW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [4:0]            wr_data,
    input  logic [1:0]            mode,
    input  logic                  hold,
    output logic [7*N_DIGITS-1:0] seg_out,
    output logic [AW-1:0]         offset,
    output logic                  wrap
);

    if (MSG_LEN < N_DIGITS) begin : g_bad_len
        $error("seg_scroll_display: MSG_LEN must be >= N_DIGITS");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("seg_scroll_display: TICK_DIV must be >= 2");
    end

    localparam logic [AW:0]   LEN_W    = (AW + 1)'(MSG_LEN);
    localparam logic [AW-1:0] OFF_LAST = AW'(MSG_LEN - 1);

    logic [4:0]    msg_q [MSG_LEN];
    logic [1:0]    mode_q;
    logic [AW-1:0] offset_q, offset_d;
    logic          wrap_q, wrap_d;
    logic          blink_q, blink_d;
    logic          mode_chg;
    logic          tick;

    assign mode_chg = (mode != mode_q);

    seg_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (mode_chg),
        .hold(hold),
        .tick(tick)
    );

    // Message buffer; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= 5'b10000;
            end
        end else if (wr_en && ({1'b0, wr_addr} < LEN_W)) begin
            msg_q[wr_addr] <= wr_data;
        end
    end

    // Next offset, wrap pulse and blink phase; a mode change restarts everything
    always_comb begin
        offset_d = offset_q;
        wrap_d   = 1'b0;
        blink_d  = blink_q;
        if (mode_chg) begin
            offset_d = '0;
            blink_d  = 1'b1;
        end else if (tick) begin
            if (mode == MODE_SCROLL) begin
                if (offset_q == OFF_LAST) begin
                    offset_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q + 1'b1;
                end
            end
            if (mode == MODE_BLINK) begin
                blink_d = ~blink_q;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            offset_q <= '0;
            wrap_q   <= 1'b0;
            blink_q  <= 1'b1;
        end else begin
            mode_q   <= mode;
            offset_q <= offset_d;
            wrap_q   <= wrap_d;
            blink_q  <= blink_d;
        end
    end

    assign offset = offset_q;
    assign wrap   = wrap_q;

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        logic [AW:0]   idx_sum;
        logic [AW-1:0] idx;
        logic [4:0]    entry;
        logic [6:0]    seg_d;
        logic [6:0]    seg_q;

        // Buffer index for this digit: offset+k folded back with one conditional subtract
        always_comb begin
            idx_sum = (AW + 1)'(k);
            if (mode_q == MODE_SCROLL) begin
                idx_sum = {1'b0, offset_q} + (AW + 1)'(k);
            end
            if (idx_sum >= LEN_W) begin
                idx_sum = idx_sum - LEN_W;
            end
            idx   = idx_sum[AW-1:0];
            entry = msg_q[idx];
            if ((mode_q == MODE_OFF) || ((mode_q == MODE_BLINK) && !blink_q) || entry[4]) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = hex_to_seg(entry[3:0]);
            end
        end

        // Registered segment drive for this digit
        always_ff @(posedge clk) begin
            if (rst) begin
                seg_q <= SEG_BLANK;
            end else begin
                seg_q <= seg_d;
            end
        end

        assign seg_out[7*k +: 7] = seg_q;
    end

endmodule

// File: tb/tb_seg_scroll_display.sv
// tb/tb_seg_scroll_display.sv - randomized self-checking bench for seg_scroll_display
module tb_seg_scroll_display;

    localparam int ND  = 4;
    localparam int ML  = 6;
    localparam int TD  = 4;
    localparam int AW  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [4:0]      wr_data;
    logic [1:0]      mode;
    logic            hold;
    logic [7*ND-1:0] seg_out;
    logic [AW-1:0]   offset;
    logic            wrap;

    seg_scroll_display #(
        .N_DIGITS(ND),
        .MSG_LEN (ML),
        .TICK_DIV(TD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .mode   (mode),
        .hold   (hold),
        .seg_out(seg_out),
        .offset (offset),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: message array plus step counter, window start and phase as integers
    logic [4:0]      m_msg [ML];
    int              m_mode;
    int              m_cnt;
    int              m_off;
    int              m_phase;
    int              m_wrap;
    logic [7*ND-1:0] m_seg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7*ND-1:0] model_view();
        logic [7*ND-1:0] v;
        for (int k = 0; k < ND; k++) begin
            int          idx;
            logic [4:0]  e;
            logic [6:0]  s;
            idx = (m_mode == 2) ? (m_off + k) % ML : k;
            e   = m_msg[idx];
            if (m_mode == 0 || (m_mode == 3 && m_phase == 0) || e[4]) s = 7'h7F;
            else s = HEX[e[3:0]];
            v[7*k +: 7] = s;
        end
        return v;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < ML; i++) m_msg[i] = 5'b10000;
            m_mode = 0; m_cnt = 0; m_off = 0; m_phase = 1; m_wrap = 0;
            m_seg = '1;
        end else begin
            bit tk;
            m_seg  = model_view();
            tk     = !hold && (m_cnt == TD - 1);
            m_wrap = 0;
            if (int'(mode) != m_mode) begin
                m_cnt = 0; m_off = 0; m_phase = 1;
            end else begin
                if (!hold) m_cnt = (m_cnt + 1) % TD;
                if (tk && mode == 2) begin
                    m_wrap = (m_off == ML - 1) ? 1 : 0;
                    m_off  = (m_off + 1) % ML;
                end
                if (tk && mode == 3) m_phase = 1 - m_phase;
            end
            if (wr_en && int'(wr_addr) < ML) m_msg[wr_addr] = wr_data;
            m_mode = int'(mode);
        end
    endtask

    task automatic cyc(input logic r, input logic we, input int a, input logic [4:0] d,
                       input logic [1:0] md, input logic h);
        rst = r; wr_en = we; wr_addr = AW'(a); wr_data = d; mode = md; hold = h;
        @(posedge clk);
        model_edge();
        #1;
        check("seg_out", 64'(seg_out), 64'(m_seg));
        check("offset",  64'(offset),  64'(m_off));
        check("wrap",    64'(wrap),    64'(m_wrap));
    endtask

    int wraps;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; mode = 2'b00; hold = 1'b0;
        #1;

        // Reset held two cycles
        cyc(1, 0, 0, 0, 2'b00, 0);
        cyc(1, 0, 0, 0, 2'b00, 0);
        check("reset_seg", 64'(seg_out), 64'(28'hFFFFFFF));
        check("reset_offset", 64'(offset), 64'd0);

        // Static: write digits 1..4
        for (int i = 0; i < 4; i++) cyc(0, 1, i, 5'(i + 1), 2'b01, 0);
        cyc(0, 0, 0, 0, 2'b01, 0);
        check("static_digits", 64'(seg_out), 64'({7'h4C, 7'h06, 7'h12, 7'h4F}));

        // Scroll: buffer 0..5, two full rotations
        for (int i = 0; i < ML; i++) cyc(0, 1, i, 5'(i), 2'b01, 0);
        cyc(0, 0, 0, 0, 2'b10, 0);
        wraps = 0;
        for (int i = 0; i < 48; i++) begin
            cyc(0, 0, 0, 0, 2'b10, 0);
            if (wrap) wraps++;
        end
        check("scroll_wraps_48clk", 64'(wraps), 64'd2);

        // Blink with a hold window
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 2'b11, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 2'b11, 1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 2'b11, 0);

        // Blank entry and out-of-range address while static
        cyc(0, 1, 2, 5'b11000, 2'b01, 0);
        cyc(0, 1, 7, 5'b00111, 2'b01, 0);
        cyc(0, 0, 0, 0, 2'b01, 0);
        check("blank_digit2", 64'(seg_out[20:14]), 64'(7'h7F));

        // Mode change and reset mid-scroll
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 2'b10, 0);
        cyc(0, 0, 0, 0, 2'b01, 0);
        check("modechg_offset0", 64'(offset), 64'd0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 2'b10, 0);
        cyc(1, 0, 0, 0, 2'b10, 0);
        check("rst_offset0", 64'(offset), 64'd0);
        check("rst_seg", 64'(seg_out), 64'(28'hFFFFFFF));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] md;
            md = mode;
            if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 7)), 5'($urandom), md, ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
